// File: rtl/int_mult_pipe_if.sv
// int_mult_pipe_if: request/result bundle of the pipelined integer multiplier.
// Signal names carry the unit's point of view (slave side).
interface int_mult_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [2:0]               operator_i;
  logic [WIDTH-1:0]         op_a_i;
  logic [WIDTH-1:0]         op_b_i;
  logic [WIDTH-1:0]         op_c_i;
  logic [$clog2(WIDTH)-1:0] imm_i;
  logic                     short_subword_i;
  logic [1:0]               short_signed_i;
  logic [TAG_WIDTH-1:0]     tag_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [WIDTH-1:0]         result_o;
  logic [TAG_WIDTH-1:0]     tag_o;
  logic                     unsupported_o;

  modport master (
    output in_valid_i, operator_i, op_a_i, op_b_i, op_c_i, imm_i,
           short_subword_i, short_signed_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, unsupported_o
  );

  modport slave (
    input  in_valid_i, operator_i, op_a_i, op_b_i, op_c_i, imm_i,
           short_subword_i, short_signed_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, unsupported_o
  );
endinterface

// File: rtl/int_mult_pipe.sv
// int_mult_pipe: elastic multiply-accumulate pipeline (MAC/MSU/subword MAC with shift).
// The full result is formed in stage 0; later stages only carry it, so bubbles can collapse freely.
module int_mult_pipe #(
  parameter int WIDTH      = 32,
  parameter int NUM_STAGES = 2,
  parameter int TAG_WIDTH  = 5
) (
  input logic              clk_i,
  input logic              rst_ni,
  int_mult_pipe_if.slave   bus
);
  localparam int H = WIDTH / 2;
  localparam logic [2:0] MUL_MAC32 = 3'd0;
  localparam logic [2:0] MUL_MSU32 = 3'd1;
  localparam logic [2:0] MUL_I     = 3'd2;
  localparam logic [2:0] MUL_IR    = 3'd3;

  logic [H-1:0]     ha, hb;
  logic [WIDTH-1:0] ea, eb, ma, mb, prod, rnd, acc, srl_v, res_c;
  logic signed [WIDTH-1:0] sra_v;
  logic             is_short, uns_c;

  always_comb begin
    is_short = bus.operator_i == MUL_I || bus.operator_i == MUL_IR;
    uns_c    = bus.operator_i > MUL_IR;
    ha       = bus.short_subword_i ? bus.op_a_i[WIDTH-1:H] : bus.op_a_i[H-1:0];
    hb       = bus.short_subword_i ? bus.op_b_i[WIDTH-1:H] : bus.op_b_i[H-1:0];
    ea       = {{H{bus.short_signed_i[0] & ha[H-1]}}, ha};
    eb       = {{H{bus.short_signed_i[1] & hb[H-1]}}, hb};
    // One shared multiplier; only the low WIDTH bits of any product are ever needed.
    ma       = is_short ? ea : bus.op_a_i;
    mb       = is_short ? eb : bus.op_b_i;
    prod     = ma * mb;
    rnd      = (bus.operator_i == MUL_IR && bus.imm_i != '0) ? (WIDTH'(1) << bus.imm_i) >> 1 : '0;
    acc      = bus.operator_i == MUL_MSU32 ? bus.op_c_i - prod : bus.op_c_i + prod + rnd;
    sra_v    = $signed(acc) >>> bus.imm_i;
    srl_v    = acc >> bus.imm_i;
    res_c    = uns_c ? '0 : !is_short ? acc : bus.short_signed_i[0] ? sra_v : srl_v;
  end

  logic [NUM_STAGES-1:0] valid_q, valid_d, go, uns_q, uns_d;
  logic [WIDTH-1:0]      res_q [NUM_STAGES];
  logic [WIDTH-1:0]      res_d [NUM_STAGES];
  logic [TAG_WIDTH-1:0]  tag_q [NUM_STAGES];
  logic [TAG_WIDTH-1:0]  tag_d [NUM_STAGES];

  // Stage k can take new content if the output retires or any stage at or after k is empty.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++)
      go[k] = bus.out_ready_i | ~&(valid_q | ~({NUM_STAGES{1'b1}} << k));
    valid_d = valid_q;
    uns_d   = uns_q;
    res_d   = res_q;
    tag_d   = tag_q;
    if (go[0]) begin
      valid_d[0] = bus.in_valid_i;
      if (bus.in_valid_i) begin
        res_d[0] = res_c;
        tag_d[0] = bus.tag_i;
        uns_d[0] = uns_c;
      end
    end
    for (int k = 1; k < NUM_STAGES; k++)
      if (go[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          res_d[k] = res_q[k-1];
          tag_d[k] = tag_q[k-1];
          uns_d[k] = uns_q[k-1];
        end
      end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_q <= '0;
      uns_q   <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      uns_q   <= uns_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
    end

  assign bus.in_ready_o    = go[0];
  assign bus.out_valid_o   = valid_q[NUM_STAGES-1];
  assign bus.result_o      = res_q[NUM_STAGES-1];
  assign bus.tag_o         = tag_q[NUM_STAGES-1];
  assign bus.unsupported_o = uns_q[NUM_STAGES-1];
endmodule

// File: tb/tb_int_mult_pipe.sv
// tb_int_mult_pipe: directed + random scoreboard bench for int_mult_pipe (WIDTH=32, NUM_STAGES=2).
module tb_int_mult_pipe;
  localparam int NS = 2;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        uns;
    int          acc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  int_mult_pipe_if #(.WIDTH(32), .TAG_WIDTH(5)) bus ();
  int_mult_pipe #(.WIDTH(32), .NUM_STAGES(NS), .TAG_WIDTH(5)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          prev_acc = 0;
  bit          acc = 0;
  bit          lat_chk = 0;
  bit          stream_chk = 0;
  logic [31:0] exp_res = '0;
  logic        exp_uns = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, b, c,
                                        input logic [4:0] imm, input logic sub, input logic [1:0] sg);
    logic [15:0] ha, hb;
    longint sa, sb, m;
    logic [31:0] lo;
    if (op == 3'd0) return {1'b0, 32'(c + a * b)};
    if (op == 3'd1) return {1'b0, 32'(c - a * b)};
    if (op > 3'd3) return {1'b1, 32'h0};
    ha = sub ? a[31:16] : a[15:0];
    hb = sub ? b[31:16] : b[15:0];
    sa = sg[0] ? longint'($signed(ha)) : longint'(ha);
    sb = sg[1] ? longint'($signed(hb)) : longint'(hb);
    m  = longint'(c) + sa * sb + ((op == 3'd3 && imm != 0) ? (longint'(1) << (imm - 1)) : 0);
    lo = m[31:0];
    return {1'b0, sg[0] ? 32'($signed(lo) >>> imm) : lo >> imm};
  endfunction

  task automatic retire();
    exp_t e;
    chk("retire_expected", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("result", bus.result_o, e.res);
      chk("tag", 32'(bus.tag_o), 32'(e.tag));
      chk("unsupported", 32'(bus.unsupported_o), 32'(e.uns));
      if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'(NS));
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    acc = bus.in_valid_i && bus.in_ready_o;
    if (acc) q.push_back('{exp_res, bus.tag_i, exp_uns, cyc});
    if (bus.out_valid_o && bus.out_ready_i) retire();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, b, c, input logic [4:0] imm,
                      input logic sub, input logic [1:0] sg, input logic [4:0] tg, input logic [32:0] ex);
    bit got = 0;
    int at = 0;
    bus.operator_i = op; bus.op_a_i = a; bus.op_b_i = b; bus.op_c_i = c; bus.imm_i = imm;
    bus.short_subword_i = sub; bus.short_signed_i = sg; bus.tag_i = tg; bus.in_valid_i = 1'b1;
    exp_uns = ex[32]; exp_res = ex[31:0];
    for (int n = 0; n < 20 && !got; n++) begin
      at = cyc;
      tick();
      got = acc;
    end
    chk("accepted", 32'(got), 32'd1);
    if (stream_chk) chk("no_bubble", 32'(at - prev_acc), 32'd1);
    prev_acc = at;
  endtask

  task automatic idle();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  logic [2:0]  rop;
  logic [31:0] ra, rb, rc;
  logic [4:0]  rimm;
  logic        rsub;
  logic [1:0]  rsg;

  initial begin
    bus.in_valid_i = 0; bus.operator_i = 0; bus.op_a_i = 0; bus.op_b_i = 0; bus.op_c_i = 0;
    bus.imm_i = 0; bus.short_subword_i = 0; bus.short_signed_i = 0; bus.tag_i = 0; bus.out_ready_i = 1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_tag", 32'(bus.tag_o), 32'd0);
    chk("rst_unsupported", 32'(bus.unsupported_o), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    lat_chk = 1;
    send(3'd0, 32'd3, 32'd5, 32'd10, 5'd0, 1'b0, 2'b00, 5'd7, {1'b0, 32'd25});
    drain();

    stream_chk = 0;
    send(3'd1, 32'd3, 32'd5, 32'd10, 5'd0, 1'b0, 2'b00, 5'd1, {1'b0, 32'hFFFF_FFFB});
    stream_chk = 1;
    send(3'd0, 32'h8000_0000, 32'd2, 32'd1, 5'd0, 1'b0, 2'b00, 5'd2, {1'b0, 32'h1});
    send(3'd3, 32'd3, 32'd3, 32'd0, 5'd1, 1'b0, 2'b00, 5'd4, {1'b0, 32'd5});
    send(3'd2, 32'hFFFF_0000, 32'h0002_0000, 32'd0, 5'd0, 1'b1, 2'b11, 5'd5, {1'b0, 32'hFFFF_FFFE});
    send(3'd2, 32'h0000_8000, 32'h0000_0002, 32'd0, 5'd4, 1'b0, 2'b00, 5'd6, {1'b0, 32'h0000_1000});
    send(3'd2, 32'h0000_8000, 32'h0000_0002, 32'd0, 5'd4, 1'b0, 2'b11, 5'd8, {1'b0, 32'hFFFF_F000});
    send(3'd5, 32'd9, 32'd9, 32'd9, 5'd0, 1'b0, 2'b00, 5'd3, {1'b1, 32'h0});
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7)); ra = $urandom; rb = $urandom; rc = $urandom;
      rimm = 5'($urandom_range(0, 31)); rsub = 1'($urandom); rsg = 2'($urandom);
      send(rop, ra, rb, rc, rimm, rsub, rsg, 5'(i + 10), model(rop, ra, rb, rc, rimm, rsub, rsg));
    end
    stream_chk = 0;
    drain();

    lat_chk = 0;
    bus.out_ready_i = 1'b0;
    send(3'd0, 32'd1, 32'd1, 32'd0, 5'd0, 1'b0, 2'b00, 5'd1, {1'b0, 32'd1});
    send(3'd0, 32'd2, 32'd3, 32'd4, 5'd0, 1'b0, 2'b00, 5'd2, {1'b0, 32'd10});
    bus.tag_i = 5'd3; bus.op_a_i = 32'd7; bus.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
      chk("bp_result_hold", bus.result_o, 32'd1);
      chk("bp_tag_hold", 32'(bus.tag_o), 32'd1);
      @(posedge clk_i); #1;
      cyc++;
    end
    bus.out_ready_i = 1'b1;
    send(3'd0, 32'd7, 32'd1, 32'd1, 5'd0, 1'b0, 2'b00, 5'd3, {1'b0, 32'd8});
    send(3'd1, 32'd2, 32'd2, 32'd5, 5'd0, 1'b0, 2'b00, 5'd4, {1'b0, 32'd1});
    drain();

    bus.out_ready_i = 1'b0;
    send(3'd0, 32'd4, 32'd4, 32'd0, 5'd0, 1'b0, 2'b00, 5'd9, {1'b0, 32'd16});
    send(3'd0, 32'd5, 32'd5, 32'd0, 5'd0, 1'b0, 2'b00, 5'd10, {1'b0, 32'd25});
    idle();
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    q.delete();
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("no_stale_out_valid", 32'(bus.out_valid_o), 32'd0);
      @(posedge clk_i); #1;
      cyc++;
    end
    lat_chk = 1;
    send(3'd0, 32'd6, 32'd7, 32'd1, 5'd0, 1'b0, 2'b00, 5'd11, {1'b0, 32'd43});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/int_mult_pipe.md
Name: int_mult_pipe

Overview:
- Pipelined, parametrised successor of the shared APU integer multiplier. Same operation set:
  - MUL_MAC32: c + a*b
  - MUL_MSU32: c - a*b
  - MUL_I: subword multiply-accumulate, then shift
  - MUL_IR: subword multiply-accumulate with rounding, then shift
- Generalised to WIDTH-bit operands and NUM_STAGES register stages. Adds a valid/ready elastic handshake, a pass-through tag, and an unsupported-operator flag.
- Sits behind the APU interconnect arbiter; one instance is shared by several cores.

Parameters:
- WIDTH, 32: operand and result width; must be even and >= 8.
- NUM_STAGES, 2: pipeline register stages, 1..4. This equals the latency and the in-flight capacity.
- TAG_WIDTH, 5: width of the pass-through request tag.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  request valid
- in_ready_o  out  1  unit accepts request this cycle
- operator_i  in  3  operator code from the APU defines package
- op_a_i  in  WIDTH  operand a
- op_b_i  in  WIDTH  operand b
- op_c_i  in  WIDTH  accumulator operand c
- imm_i  in  $clog2(WIDTH)  shift amount for MUL_I and MUL_IR
- short_subword_i  in  1  selects the upper half of a and b (1) or the lower half (0)
- short_signed_i  in  2  bit0: a-half signed and arithmetic shift; bit1: b-half signed
- tag_i  in  TAG_WIDTH  request tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- result_o  out  WIDTH  result
- tag_o  out  TAG_WIDTH  tag of the result
- unsupported_o  out  1  operator was not one of the four supported codes

Behaviour:
- Reset: asynchronous on rst_ni low.
  - All stage valid bits clear; out_valid_o=0.
  - result_o=0, tag_o=0, unsupported_o=0.
  - Any in-flight operations are discarded and never emitted.
  - in_ready_o=1 after reset.
- Handshake:
  - A request transfers when in_valid_i && in_ready_o.
  - A result transfers when out_valid_o && out_ready_i.
  - While out_valid_o=1 and out_ready_i=0, result_o, tag_o and unsupported_o hold stable and out_valid_o stays 1.
- Pipeline:
  - Stage k advances when stage k+1 is empty or stage k+1 is advancing. Bubbles collapse.
  - The last stage drives the outputs directly from its registers.
  - in_ready_o = stage 0 empty, or stage 0 advancing. It is combinational from out_ready_i through the stage valids.
- Latency and throughput:
  - A request accepted in cycle t is presented in cycle t+NUM_STAGES if no stall occurs.
  - Sustained throughput is 1 operation per cycle.
  - Capacity is NUM_STAGES operations; with out_ready_i=0, in_ready_o drops after NUM_STAGES accepts.
  - Simultaneous accept and retire in a full pipeline is allowed; no bubble is inserted.
- Ordering: results and tags leave in acceptance order.
- Arithmetic, MAC and MSU:
  - MAC: result = (c + a*b) mod 2^WIDTH.
  - MSU: result = (c - a*b) mod 2^WIDTH.
  - Operands are treated as signed; the low WIDTH bits are identical for unsigned operands.
- Arithmetic, short (MUL_I and MUL_IR):
  - Let H = WIDTH/2. ha = op_a half, hb = op_b half, both selected by short_subword_i.
  - Each half is extended to H+1 bits: ha by short_signed_i[0], hb by short_signed_i[1].
  - mac = c + ha*hb + rnd, computed at WIDTH+2 bits with c zero-extended.
  - rnd = 2^(imm_i-1) for MUL_IR with imm_i != 0; rnd = 0 otherwise.
  - result = mac[WIDTH-1:0] shifted right by imm_i. The shift is arithmetic (fills with mac[WIDTH-1]) if short_signed_i[0]=1, logical otherwise.
  - imm_i=0 means no shift.
- Unsupported operator codes: result_o=0 and unsupported_o=1. The operation still occupies the pipe and retires normally with its tag.
- Timing split: the multiply is computed in stage 0. Stages 1..N-1 carry registered partial and final values; implementation may retime within stages. Operand registers update only on accept.

Test Plan:
- WIDTH=32, NUM_STAGES=2. MAC a=3, b=5, c=10, tag=7, out_ready_i=1 -> out_valid_o exactly 2 cycles after accept, result 25, tag_o 7, unsupported_o 0.
- MSU a=3, b=5, c=10 -> 0xFFFFFFFB. MAC a=0x80000000, b=2, c=1 -> 0x00000001 (wrap).
- MUL_IR subword=0, a=0x00000003, b=0x00000003, c=0, imm=1 -> 5.
- MUL_I subword=1, signed=2'b11, a=0xFFFF0000, b=0x00020000, c=0, imm=0 -> 0xFFFFFFFE.
- MUL_I a-low=0x8000, b-low=0x0002, c=0, imm=4:
  - signed=2'b00 -> 0x00001000.
  - signed=2'b11 -> 0xFFFFF000.
- Backpressure: hold out_ready_i=0, stream 4 tagged requests 1..4:
  - in_ready_o falls after 2 accepts.
  - Release out_ready_i -> tags 1,2,3,4 in order, results stable while stalled.
  - Zero bubbles when in_valid_i and out_ready_i stay high.
- Unsupported operator code with tag=3 -> result 0, unsupported_o=1, tag_o 3.
- Assert rst_ni low mid-stream with 2 in flight -> out_valid_o=0 asynchronously, no stale results after release, in_ready_o=1.
